// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate-extension unit.
//   Extends an IN_W-bit immediate to OUT_W bits (ZERO / SIGN / UPPER / BRANCH)
//   behind a valid/ready handshake. An output register plus a 1-entry skid
//   register give full throughput and an in_ready that depends only on the
//   skid flag, never on out_ready.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream offers imm_in/ext_op
//   in_ready   unit can accept this cycle
//   ext_op     00 ZERO, 01 SIGN, 10 UPPER, 11 BRANCH
//   imm_in     immediate field
//   out_valid  out_data holds a result
//   out_ready  downstream accepts out_data
//   out_data   extended result
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ext_op,
  input  logic [IN_W-1:0]  imm_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  generate
    if (OUT_W < IN_W + 2) begin : g_bad_params
      $error("imm_ext_pipe: OUT_W must be >= IN_W+2");
    end
  endgenerate

  typedef enum logic [1:0] {
    OP_ZERO   = 2'b00,
    OP_SIGN   = 2'b01,
    OP_UPPER  = 2'b10,
    OP_BRANCH = 2'b11
  } ext_op_e;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] skid_data;
  logic             skid_valid;
  logic             accept;
  logic             drain;

  assign sext = {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in};

  always_comb begin
    ext = '0;
    case (ext_op_e'(ext_op))
      OP_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm_in};
      OP_SIGN:   ext = sext;
      OP_UPPER:  ext = {imm_in, {(OUT_W-IN_W){1'b0}}};
      OP_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
      default:   ext = '0;
    endcase
  end

  // Ready depends only on the skid flag; it is forced low while in reset.
  assign in_ready = ~skid_valid & ~rst;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      // Skid full means in_ready is low, so nothing new can arrive here.
      if (drain) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || drain) begin
        out_data  <= ext;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= ext;
        skid_valid <= 1'b1;
      end
    end else if (drain) begin
      // out_data keeps its last value once the result is consumed.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Testbench for imm_ext_pipe: two instances, (16,32) and (8,16), share all
// control inputs and are checked every cycle against a queue-based model
// (capacity 2, FIFO order, out_data holding its last value).
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  ext_op;
  logic [15:0] imm_in;
  logic        out_ready;

  logic        in_ready_a, out_valid_a;
  logic [31:0] out_data_a;
  logic        in_ready_b, out_valid_b;
  logic [15:0] out_data_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] last_a = 0;
  logic [31:0] last_b = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .ext_op(ext_op), .imm_in(imm_in), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .ext_op(ext_op), .imm_in(imm_in[7:0]), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b)
  );

  // Reference extension from the arithmetic definition of each mode.
  function automatic logic [31:0] ref_ext(input int op, input longint imm,
                                          input int in_w, input int out_w);
    longint one = 1;
    longint u, s, r, m;
    u = imm % (one << in_w);
    s = (u >= (one << (in_w - 1))) ? u - (one << in_w) : u;
    m = one << out_w;
    case (op)
      0:       r = u;
      1:       r = s;
      2:       r = u * (one << (out_w - in_w));
      default: r = s * 4;
    endcase
    r = ((r % m) + m) % m;
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance it.
  task automatic step();
    bit acc, drn;
    @(negedge clk);
    chk("a.in_ready",  {31'b0, in_ready_a},  {31'b0, !rst && q_a.size() < 2});
    chk("a.out_valid", {31'b0, out_valid_a}, {31'b0, q_a.size() > 0});
    chk("a.out_data",  out_data_a, (q_a.size() > 0) ? q_a[0] : last_a);
    chk("b.in_ready",  {31'b0, in_ready_b},  {31'b0, !rst && q_b.size() < 2});
    chk("b.out_valid", {31'b0, out_valid_b}, {31'b0, q_b.size() > 0});
    chk("b.out_data",  {16'b0, out_data_b}, (q_b.size() > 0) ? q_b[0] : last_b);
    acc = in_valid && !rst && q_a.size() < 2;
    drn = out_ready && q_a.size() > 0;
    @(posedge clk);
    if (rst) begin
      q_a.delete(); q_b.delete();
      last_a = 0; last_b = 0;
    end else begin
      if (drn) begin
        last_a = q_a.pop_front();
        last_b = q_b.pop_front();
      end
      if (acc) begin
        q_a.push_back(ref_ext(int'(ext_op), longint'(imm_in), 16, 32));
        q_b.push_back(ref_ext(int'(ext_op), longint'(imm_in[7:0]), 8, 16));
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [15:0] imm, input bit rdy);
    in_valid = v; ext_op = op; imm_in = imm; out_ready = rdy;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 2'b00, 16'h0, 0);
    // Reset: in_ready low while rst is high, outputs cleared.
    step(); step();
    rst = 1'b0;
    step();
    chk("rst.in_ready_after", {31'b0, in_ready_a}, 32'd1);

    // Mode constants with imm 0x8004, one cycle latency each.
    for (int op = 0; op < 4; op++) begin
      drive(1, op[1:0], 16'h8004, 1);
      step();
      drive(0, 2'b00, 16'h0, 1);
      case (op)
        0: chk("mode.zero",   out_data_a, 32'h00008004);
        1: chk("mode.sign",   out_data_a, 32'hFFFF8004);
        2: chk("mode.upper",  out_data_a, 32'h80040000);
        default: chk("mode.branch", out_data_a, 32'hFFFE0010);
      endcase
      chk("mode.valid", {31'b0, out_valid_a}, 32'd1);
      step();
    end

    // Streaming: 8 back-to-back inputs, ready held high.
    for (int i = 0; i < 8; i++) begin
      drive(1, i[1:0], 16'(i * 16'h1357 + 16'h0081), 1);
      step();
      chk("stream.in_ready", {31'b0, in_ready_a}, 32'd1);
    end
    drive(0, 2'b00, 16'h0, 1);
    step(); step();

    // Stall: push A then B with ready low, A held, B in skid.
    drive(1, 2'b01, 16'hA5A5, 0); step();
    drive(1, 2'b10, 16'h1234, 0); step();
    drive(0, 2'b00, 16'h0, 0);
    step();
    chk("stall.held_A",   out_data_a, 32'hFFFFA5A5);
    chk("stall.in_ready", {31'b0, in_ready_a}, 32'd0);
    step();
    out_ready = 1'b1;
    step();
    chk("stall.B_out", out_data_a, 32'h12340000);
    chk("stall.in_ready_back", {31'b0, in_ready_a}, 32'd1);
    step(); step();

    // Reset with skid full: neither entry may appear afterwards.
    drive(1, 2'b11, 16'h0F0F, 0); step();
    drive(1, 2'b00, 16'hF0F0, 0); step();
    drive(0, 2'b00, 16'h0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rstfull.out_valid", {31'b0, out_valid_a}, 32'd0);
    chk("rstfull.in_ready",  {31'b0, in_ready_a},  32'd1);
    chk("rstfull.out_data",  out_data_a, 32'd0);
    step(); step();

    // Random valid/ready traffic with an occasional reset.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            16'($urandom), $urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    drive(0, 2'b00, 16'h0, 1);
    for (int i = 0; i < 4; i++) step();
    chk("final.empty", {31'b0, out_valid_a}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
